// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the mem_arbiter block.
//   state_t  : controller states (RST_WAIT, IDLE, XFER)
//   owner_t  : which requester owns the transfer in flight (OWN_IF, OWN_LS)
//   SZ_*     : access-size codes as seen on *_size and mem_access_size
//   size_beats / size_bytes / size_legal : helpers for size decoding
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        IDLE     = 2'd1,
        XFER     = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [2:0] SZ_W1   = 3'd0;
    localparam logic [2:0] SZ_W4   = 3'd1;
    localparam logic [2:0] SZ_W8   = 3'd2;
    localparam logic [2:0] SZ_W16  = 3'd3;
    localparam logic [2:0] SZ_BYTE = 3'd4;
    localparam logic [2:0] SZ_HALF = 3'd5;

    // Number of memory beats for a size code; sub-word accesses are one beat.
    function automatic logic [4:0] size_beats(input logic [2:0] size);
        case (size)
            SZ_W4:   size_beats = 5'd4;
            SZ_W8:   size_beats = 5'd8;
            SZ_W16:  size_beats = 5'd16;
            default: size_beats = 5'd1;
        endcase
    endfunction

    // Bytes touched by an access of the given size.
    function automatic logic [6:0] size_bytes(input logic [2:0] size);
        case (size)
            SZ_BYTE: size_bytes = 7'd1;
            SZ_HALF: size_bytes = 7'd2;
            default: size_bytes = {size_beats(size), 2'b00};
        endcase
    endfunction

    // Fetch port only knows word bursts; load/store also has byte and half.
    function automatic logic size_legal(input logic [2:0] size, input logic allow_sub);
        size_legal = allow_sub ? (size <= SZ_HALF) : (size <= SZ_W16);
    endfunction

endpackage

// File: rtl/mem_arb_check.sv
// mem_arb_check: combinational request validation for one requester port.
//   addr  in  32  request byte address
//   size  in  3   request size code
//   err   out 1   request must be rejected (bad size, out of window, misaligned)
// Parameters: START_ADDR / MEM_BYTES describe the memory window; ALLOW_SUB
// enables the byte/half-word size codes (load/store port only).
import mem_arb_pkg::*;

module mem_arb_check #(
    parameter logic [31:0] START_ADDR = 32'h8002_0000,
    parameter int          MEM_BYTES  = 1024,
    parameter bit          ALLOW_SUB  = 1'b1
) (
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    output logic        err
);

    localparam logic [32:0] LIMIT = 33'(MEM_BYTES);

    logic [32:0] offset;
    logic [32:0] end_off;
    logic        below;
    logic        over;
    logic        misaligned;

    always_comb begin
        // 33-bit arithmetic so a large offset plus burst length cannot wrap.
        offset     = {1'b0, addr} - {1'b0, START_ADDR};
        end_off    = offset + {26'd0, size_bytes(size)};
        below      = (addr < START_ADDR);
        over       = (end_off > LIMIT);
        misaligned = 1'b0;
        if (size <= SZ_W16) begin
            misaligned = (addr[1:0] != 2'b00);
        end else if (size == SZ_HALF) begin
            misaligned = addr[0];
        end
        err = !size_legal(size, ALLOW_SUB) || below || over || misaligned;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares single-port data_memory2 between the instruction-fetch
// port (if_*, read-only) and the load/store port (ls_*, read/write).
//   clk, rst_n                 clock, async active-low reset
//   if_req/addr/size           fetch request     -> if_gnt, if_err, if_rvalid, if_rdata
//   ls_req/addr/size/rw/wdata  load/store request -> ls_gnt, ls_err, ls_rvalid, ls_rdata, ls_wack
//   mem_enable/rw/addr/din/access_size -> memory;  mem_dout, mem_busy <- memory
// Optional build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
// load/store grants while fetch waits, fetch wins the next slot.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter logic [31:0] START_ADDR   = 32'h8002_0000,
    parameter int          MEM_BYTES    = 1024,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic [2:0]  if_size,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    input  logic [2:0]  ls_size,
    input  logic        ls_rw,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        ls_wack,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [2:0]  mem_access_size,
    input  logic [31:0] mem_dout,
    input  logic        mem_busy
);

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    owner_t      owner_q, owner_nx;
    logic [2:0]  size_q, size_nx;
    logic        rw_q, rw_nx;

    logic        if_bad, ls_bad;
    logic        slot, ls_win, if_win, ls_ok, if_ok;
    logic        fetch_first;

    mem_arb_check #(.START_ADDR(START_ADDR), .MEM_BYTES(MEM_BYTES), .ALLOW_SUB(1'b0))
        u_if_check (.addr(if_addr), .size(if_size), .err(if_bad));

    mem_arb_check #(.START_ADDR(START_ADDR), .MEM_BYTES(MEM_BYTES), .ALLOW_SUB(1'b1))
        u_ls_check (.addr(ls_addr), .size(ls_size), .err(ls_bad));

    // The last beat of a transfer doubles as the next grant slot.
    assign slot   = (state == IDLE) || ((state == XFER) && (cnt == 5'd1));
    assign ls_win = slot && ls_req && !(fetch_first && if_req);
    assign if_win = slot && if_req && !ls_win;
    assign ls_ok  = ls_win && !ls_bad;
    assign if_ok  = if_win && !if_bad;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] streak;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (!if_req || if_win) begin
            streak <= '0;
        end else if (ls_win && (streak < SW'(STARVE_LIMIT))) begin
            streak <= streak + 1'b1;
        end
    end

    assign fetch_first = (streak >= SW'(STARVE_LIMIT));
`else
    assign fetch_first = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_WAIT;
            cnt     <= 5'd0;
            owner_q <= OWN_IF;
            size_q  <= 3'd0;
            rw_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            owner_q <= owner_nx;
            size_q  <= size_nx;
            rw_q    <= rw_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        owner_nx        = owner_q;
        size_nx         = size_q;
        rw_nx           = rw_q;
        if_gnt          = if_win;
        if_err          = if_win && if_bad;
        if_rvalid       = 1'b0;
        if_rdata        = 32'd0;
        ls_gnt          = ls_win;
        ls_err          = ls_win && ls_bad;
        ls_rvalid       = 1'b0;
        ls_rdata        = 32'd0;
        ls_wack         = 1'b0;
        mem_enable      = 1'b0;
        mem_rw          = 1'b0;
        mem_addr        = 32'd0;
        mem_din         = 32'd0;
        mem_access_size = 3'd0;

        case (state)
            RST_WAIT: begin
                if (!mem_busy) begin
                    state_nx = IDLE;
                end
            end
            XFER: begin
                cnt_nx          = cnt - 5'd1;
                mem_access_size = size_q;
                mem_rw          = rw_q;
                if (cnt == 5'd1) begin
                    state_nx = IDLE;
                end
                if (owner_q == OWN_LS) begin
                    if (rw_q) begin
                        mem_din = ls_wdata;
                        ls_wack = (cnt >= 5'd2);
                    end else begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = mem_dout;
                    end
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_dout;
                end
            end
            default: ;
        endcase

        // A valid grant in the slot overrides the latched transfer attributes.
        if (ls_ok) begin
            mem_enable      = 1'b1;
            mem_addr        = ls_addr;
            mem_rw          = ls_rw;
            mem_access_size = ls_size;
            if (ls_rw) begin
                mem_din = ls_wdata;
                ls_wack = 1'b1;
            end
            state_nx = XFER;
            cnt_nx   = size_beats(ls_size);
            owner_nx = OWN_LS;
            size_nx  = ls_size;
            rw_nx    = ls_rw;
        end else if (if_ok) begin
            mem_enable      = 1'b1;
            mem_addr        = if_addr;
            mem_rw          = 1'b0;
            mem_access_size = if_size;
            state_nx        = XFER;
            cnt_nx          = size_beats(if_size);
            owner_nx        = OWN_IF;
            size_nx         = if_size;
            rw_nx           = 1'b0;
        end
    end

    // The memory must be idle whenever a fresh transfer starts from IDLE.
    a_no_grant_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n)
        !((state == IDLE) && mem_enable && mem_busy));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam logic [31:0] START = 32'h8002_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [2:0]  if_size;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        ls_req, ls_rw;
    logic [31:0] ls_addr, ls_wdata;
    logic [2:0]  ls_size;
    logic        ls_gnt, ls_rvalid, ls_err, ls_wack;
    logic [31:0] ls_rdata;
    logic        mem_enable, mem_rw;
    logic [31:0] mem_addr, mem_din;
    logic [2:0]  mem_access_size;
    logic [31:0] mem_dout;
    logic        mem_busy;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_size(if_size),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_size(ls_size), .ls_rw(ls_rw),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ls_err(ls_err), .ls_wack(ls_wack),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_access_size(mem_access_size), .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    // Behavioural stand-in for data_memory2 (busy is driven by the bench).
    logic [31:0] mem_img [0:255];
    logic [31:0] mdout = 32'd0;
    int          rem = 0;
    logic [31:0] ptr = 32'd0;
    logic        mrw = 1'b0;
    assign mem_dout = mdout;

    function automatic int mbeats(input logic [2:0] s);
        case (s)
            3'd1: return 4;
            3'd2: return 8;
            3'd3: return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] w;
        logic [31:0] off;
        off = a - START;
        w = mem_img[off[9:2]];
        if (s == 3'd4) return {24'd0, w[8*a[1:0] +: 8]};
        if (s == 3'd5) return {16'd0, w[16*a[1] +: 16]};
        return w;
    endfunction

    always @(posedge clk) begin
        logic [31:0] off;
        if (mem_enable) begin
            mrw = mem_rw;
            if (mem_rw) begin
                off = mem_addr - START;
                mem_img[off[9:2]] = mem_din;
            end else begin
                mdout <= mread(mem_addr, mem_access_size);
            end
            rem = mbeats(mem_access_size) - 1;
            ptr = mem_addr + 32'd4;
        end else if (rem > 0) begin
            if (mrw) begin
                off = ptr - START;
                mem_img[off[9:2]] = mem_din;
            end else begin
                mdout <= mread(ptr, 3'd0);
            end
            ptr = ptr + 32'd4;
            rem = rem - 1;
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; mem_busy = 1'b1;
        if_req = 1'b1; if_addr = START; if_size = 3'd0;
        #2;
        total++;
        if ({if_gnt, ls_gnt, mem_enable, if_rvalid, ls_rvalid, ls_wack, if_err, ls_err} !== 8'd0)
            $display("FAIL reset_outputs got %b exp 00000000",
                     {if_gnt, ls_gnt, mem_enable, if_rvalid, ls_rvalid, ls_wack, if_err, ls_err});
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; total++;
            if (if_gnt !== 1'b0) $display("FAIL rst_wait_busy_gnt cyc %0d got %b exp 0", i, if_gnt);
            else pass_cnt++;
            @(negedge clk);
        end
        mem_busy = 1'b0; if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch_burst;
        @(negedge clk);
        if_req = 1'b1; if_addr = START; if_size = 3'd1;
        #1; total++;
        if ({if_gnt, if_err, mem_enable, mem_rw} !== 4'b1010 || mem_access_size !== 3'd1 || mem_addr !== START)
            $display("FAIL fetch_grant got %b sz %0d addr %h exp 1010 sz 1 addr %h",
                     {if_gnt, if_err, mem_enable, mem_rw}, mem_access_size, mem_addr, START);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); if_req = 1'b0;
            #1; total++;
            if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0000 + k || mem_enable !== 1'b0)
                $display("FAIL fetch_beat%0d got v=%b d=%h en=%b exp v=1 d=%h en=0",
                         k, if_rvalid, if_rdata, mem_enable, 32'h1000_0000 + k);
            else pass_cnt++;
        end
        @(negedge clk); #1; total++;
        if (if_rvalid !== 1'b0) $display("FAIL fetch_end got %b exp 0", if_rvalid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        ls_req = 1'b1; ls_rw = 1'b1; ls_size = 3'd0; ls_addr = START + 32'h10; ls_wdata = 32'hDEAD_BEEF;
        #1; total++;
        if ({ls_gnt, ls_wack, mem_enable, mem_rw} !== 4'b1111 || mem_din !== 32'hDEAD_BEEF)
            $display("FAIL write_grant got %b din %h exp 1111 din deadbeef",
                     {ls_gnt, ls_wack, mem_enable, mem_rw}, mem_din);
        else pass_cnt++;
        @(negedge clk); ls_rw = 1'b0;
        #1; total++;
        if ({ls_gnt, ls_wack, mem_enable, mem_rw, ls_rvalid} !== 5'b10100)
            $display("FAIL b2b_read_grant got %b exp 10100", {ls_gnt, ls_wack, mem_enable, mem_rw, ls_rvalid});
        else pass_cnt++;
        @(negedge clk); ls_req = 1'b0;
        #1; total++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hDEAD_BEEF)
            $display("FAIL b2b_readback got v=%b d=%h exp v=1 d=deadbeef", ls_rvalid, ls_rdata);
        else pass_cnt++;
        @(negedge clk); #1; total++;
        if (ls_rvalid !== 1'b0) $display("FAIL b2b_end got %b exp 0", ls_rvalid);
        else pass_cnt++;
    endtask

    task automatic test_priority;
        @(negedge clk);
        ls_req = 1'b1; ls_rw = 1'b0; ls_size = 3'd2; ls_addr = START + 32'h20;
        if_req = 1'b1; if_size = 3'd2; if_addr = START + 32'h40;
        #1; total++;
        if ({ls_gnt, if_gnt} !== 2'b10) $display("FAIL prio_grant got %b exp 10", {ls_gnt, if_gnt});
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); ls_req = 1'b0;
            #1; total++;
            if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h1000_0008 + k || if_gnt !== (k == 7))
                $display("FAIL prio_ls_beat%0d got v=%b d=%h ifg=%b exp v=1 d=%h ifg=%b",
                         k, ls_rvalid, ls_rdata, if_gnt, 32'h1000_0008 + k, (k == 7));
            else pass_cnt++;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); if_req = 1'b0;
            #1; total++;
            if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0010 + k || ls_rvalid !== 1'b0)
                $display("FAIL prio_if_beat%0d got v=%b d=%h lsv=%b exp v=1 d=%h lsv=0",
                         k, if_rvalid, if_rdata, ls_rvalid, 32'h1000_0010 + k);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_errors;
        logic [31:0] ea [6] = '{START + 32'h3FE, START + 32'h1, 32'h8000_0000,
                                START + 32'h3C4, START, START + 32'h3FC};
        logic [2:0]  es [6] = '{3'd0, 3'd5, 3'd0, 3'd3, 3'd6, 3'd2};
        logic [31:0] oa [3] = '{START + 32'h3FC, START + 32'h2, START + 32'h3};
        logic [2:0]  os [3] = '{3'd0, 3'd5, 3'd4};
        logic [31:0] od [3] = '{32'h1000_00FF, 32'h0000_1000, 32'h0000_0010};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ls_req = 1'b1; ls_rw = 1'b0; ls_addr = ea[i]; ls_size = es[i];
            #1; total++;
            if ({ls_gnt, ls_err, mem_enable} !== 3'b110)
                $display("FAIL err_case%0d got %b exp 110", i, {ls_gnt, ls_err, mem_enable});
            else pass_cnt++;
        end
        @(negedge clk);
        ls_req = 1'b0; if_req = 1'b1; if_addr = START; if_size = 3'd4;
        #1; total++;
        if ({if_gnt, if_err, mem_enable} !== 3'b110)
            $display("FAIL err_fetch_byte got %b exp 110", {if_gnt, if_err, mem_enable});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_req = 1'b0; ls_req = 1'b1; ls_addr = oa[i]; ls_size = os[i];
            #1; total++;
            if ({ls_gnt, ls_err, mem_enable} !== 3'b101)
                $display("FAIL ok_grant%0d got %b exp 101", i, {ls_gnt, ls_err, mem_enable});
            else pass_cnt++;
            @(negedge clk); ls_req = 1'b0;
            #1; total++;
            if (ls_rvalid !== 1'b1 || ls_rdata !== od[i])
                $display("FAIL ok_data%0d got v=%b d=%h exp v=1 d=%h", i, ls_rvalid, ls_rdata, od[i]);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_starvation;
        logic exp_if;
        @(negedge clk);
        ls_req = 1'b1; ls_rw = 1'b0; ls_size = 3'd0; ls_addr = START;
        if_req = 1'b1; if_size = 3'd0; if_addr = START + 32'h4;
        for (int c = 0; c < 8; c++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = (c == 4);
`else
            exp_if = 1'b0;
`endif
            #1; total++;
            if ({ls_gnt, if_gnt} !== {!exp_if, exp_if})
                $display("FAIL starve_cyc%0d got %b exp %b", c, {ls_gnt, if_gnt}, {!exp_if, exp_if});
            else pass_cnt++;
            @(negedge clk);
        end
        ls_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_midburst;
        @(negedge clk);
        ls_req = 1'b1; ls_rw = 1'b0; ls_size = 3'd3; ls_addr = START;
        #1; total++;
        if (ls_gnt !== 1'b1) $display("FAIL mid_grant got %b exp 1", ls_gnt);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); ls_req = 1'b0;
            #1; total++;
            if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h1000_0000 + k)
                $display("FAIL mid_beat%0d got v=%b d=%h exp v=1 d=%h", k, ls_rvalid, ls_rdata, 32'h1000_0000 + k);
            else pass_cnt++;
        end
        rst_n = 1'b0; mem_busy = 1'b1;
        ls_req = 1'b1; ls_size = 3'd0; ls_addr = START + 32'h8;
        #1; total++;
        if ({ls_rvalid, ls_gnt, mem_enable, ls_wack} !== 4'd0 || ls_rdata !== 32'd0)
            $display("FAIL mid_reset_clear got %b d=%h exp 0000 d=0",
                     {ls_rvalid, ls_gnt, mem_enable, ls_wack}, ls_rdata);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; total++;
            if (ls_gnt !== 1'b0 || ls_rvalid !== 1'b0)
                $display("FAIL mid_busy_hold%0d got g=%b v=%b exp 0 0", i, ls_gnt, ls_rvalid);
            else pass_cnt++;
            @(negedge clk);
        end
        mem_busy = 1'b0;
        #1; total++;
        if (ls_gnt !== 1'b0) $display("FAIL mid_leave_wait got %b exp 0", ls_gnt);
        else pass_cnt++;
        @(negedge clk); #1; total++;
        if ({ls_gnt, mem_enable} !== 2'b11) $display("FAIL mid_regrant got %b exp 11", {ls_gnt, mem_enable});
        else pass_cnt++;
        @(negedge clk); ls_req = 1'b0;
        #1; total++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h1000_0002)
            $display("FAIL mid_regrant_data got v=%b d=%h exp v=1 d=10000002", ls_rvalid, ls_rdata);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_img[i] = 32'h1000_0000 + 32'(i);
        ls_req = 1'b0; ls_rw = 1'b0; ls_addr = START; ls_size = 3'd0; ls_wdata = 32'd0;
        test_reset();
        test_fetch_burst();
        test_back_to_back();
        test_priority();
        test_errors();
        test_starvation();
        test_reset_midburst();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
